pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Program-counter register and next-PC selector for the single-cycle datapath. It decodes the current instruction's control fields and picks the next fetch address from four sources: sequential PC+4, taken branch, absolute jump, or the register target delivered by the jump-register control path (`ReadData1` when the instruction is `jr`, otherwise high-Z). It adds a one-cycle flush after every redirect, a stall hold, and a sticky fault state for misaligned targets.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  hold PC and state this cycle.
- `opcode`  input  3  opcode of the instruction at `pc`.
- `func`  input  6  function field of the instruction at `pc`.
- `jr_target`  input  32  register target from the jump-register path; may be high-Z when not `jr`.
- `branch_taken`  input  1  branch condition resolved true for the current instruction.
- `branch_offset`  input  16  signed word offset.
- `jump_index`  input  26  absolute word index.
- `pc`  output  32  current fetch address.
- `pc_plus4`  output  32  `pc + 4`, combinational.
- `flush`  output  1  squash the instruction fetched this cycle.
- `fault`  output  1  misaligned target trapped (sticky).
- `redirect_count`  output  16  count of taken redirects (see Configuration).

## Operation
- Decode:
  - `is_jr` = ({opcode, func} == 9'b000_001000).
  - `is_j` = (opcode == 3'b010).
  - `is_br` = `branch_taken`.
- Priority: jr > j > branch > sequential.
- Targets, all modulo 2^32:
  - jr: `jr_target`.
  - j: {pc_plus4[31:28], jump_index, 2'b00}.
  - branch: pc_plus4 + (sign_extend(branch_offset) << 2).
  - sequential: `pc_plus4`.
- `jr_target` is sampled only when `is_jr` is true. X/Z on it at any other time must not affect state.
- States:
  - RUN:
    - `stall`: hold PC and state.
    - Else, redirect with target[1:0]==0: load PC = target, go to FLUSH, increment count.
    - Else, redirect with target[1:0]!=0: go to FAULT, PC unchanged.
    - Else: PC = pc_plus4.
  - FLUSH: `flush`=1. All control inputs are ignored because they belong to the squashed instruction.
    - `stall`: stay in FLUSH.
    - Else: PC = pc_plus4, go to RUN.
  - FAULT: `fault`=1, PC frozen, all inputs ignored. Exit only via reset.
- Wrap-around: PC 32'hFFFF_FFFC sequential → 32'h0000_0000. No error is raised.

## Timing
- Reset (async assert, sync release):
  - `pc`=RESET_PC, state RUN.
  - `flush`=0, `fault`=0, `redirect_count`=0.
  - `pc_plus4`=RESET_PC+4.
- Next-PC latency is one cycle: inputs sampled at edge N appear on `pc` after edge N.
- `flush` and `fault` are registered state decodes, with no combinational path from inputs.
- Stall and redirect in the same cycle: stall wins, and the redirect is re-evaluated next cycle (the instruction is held).
- Reset asserted mid-FLUSH or mid-FAULT returns immediately to reset values.

## Configuration
- `PC_REDIRECT_COUNT_EN` defined:
  - `redirect_count` increments on each accepted, aligned redirect leaving RUN.
  - Saturates at 16'hFFFF.
  - Misaligned traps are not counted.
- Undefined: counter logic is absent and `redirect_count` is tied to 16'h0000.

## Test plan
- Reset with RESET_PC=32'h0000_0100, then 3 idle cycles → pc 0x100, 0x104, 0x108, 0x10C; flush=0, fault=0.
- At pc=0x200, opcode=000, func=001000, jr_target=0x0000_0400 → next pc=0x400, flush=1 for one cycle, then pc=0x404; redirect_count=1 with macro, 0 without.
- At pc=0x200, branch_taken=1, branch_offset=16'hFFFF, with opcode=010 and jump_index=0x40 simultaneously → jump wins: pc=0x100. Then in FLUSH, branch_taken=1 is ignored and pc=0x104.
- jr_target=0x0000_0402 with jr decoded → fault=1 the next cycle, pc stays 0x200 for 5+ cycles; rst_n low → fault=0, pc=RESET_PC.
- stall=1 together with jr_target=0x400 for 2 cycles → pc holds; release → pc=0x400. Separately, pc=0xFFFF_FFFC sequential → pc=0x0000_0000.

Source files
------------

// File: rtl/pc_next_if.sv
// Fetch-side bundle between the PC/next-PC unit and its surroundings.
// The slave modport is the PC unit; the master modport drives decode fields
// and the jump-register target, and observes the fetch address and status.
interface pc_next_if;
    logic        stall;
    logic [2:0]  opcode;
    logic [5:0]  func;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        fault;
    logic [15:0] redirect_count;

    modport master (
        output stall, opcode, func, jr_target, branch_taken, branch_offset, jump_index,
        input  pc, pc_plus4, flush, fault, redirect_count
    );

    modport slave (
        input  stall, opcode, func, jr_target, branch_taken, branch_offset, jump_index,
        output pc, pc_plus4, flush, fault, redirect_count
    );
endinterface

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the single-cycle datapath.
// Sources in priority order: jr > j > taken branch > pc+4. Every accepted
// redirect is followed by one flush cycle; a misaligned target traps into a
// sticky fault state that only reset clears.
// Optional: define PC_REDIRECT_COUNT_EN to build the saturating redirect
// counter; otherwise redirect_count is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal fetch, current instruction's control is honoured
// ST_FLUSH | instruction fetched after a redirect is squashed
// ST_FAULT | misaligned target trapped, PC frozen until reset
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic     clk,
    input logic     rst_n,
    pc_next_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] pc_plus4;
    logic        is_jr, is_j, is_br, redirect;
    logic [31:0] target;
    logic        count_inc;

    assign pc_plus4 = pc_q + 32'd4;
    assign is_jr    = ({bus.opcode, bus.func} == 9'b000_001000);
    assign is_j     = (bus.opcode == 3'b010);
    assign is_br    = bus.branch_taken;
    assign redirect = is_jr | is_j | is_br;

    // Target select; jr_target is only looked at when jr decodes, so a
    // floating register path cannot leak into the PC.
    always_comb begin
        target = pc_plus4;
        if (is_jr) begin
            target = bus.jr_target;
        end else if (is_j) begin
            target = {pc_plus4[31:28], bus.jump_index, 2'b00};
        end else if (is_br) begin
            target = pc_plus4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
        end
    end

    // State and PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pc_q  <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
        end
    end

    // Next-state and next-PC; stall freezes everything, FLUSH ignores the
    // squashed instruction's control fields.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        count_inc = 1'b0;
        case (state)
            ST_RUN: begin
                if (!bus.stall) begin
                    if (redirect) begin
                        if (target[1:0] == 2'b00) begin
                            pc_nxt    = target;
                            state_nxt = ST_FLUSH;
                            count_inc = 1'b1;
                        end else begin
                            state_nxt = ST_FAULT;
                        end
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end
            end
            ST_FLUSH: begin
                if (!bus.stall) begin
                    pc_nxt    = pc_plus4;
                    state_nxt = ST_RUN;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_FAULT;
            end
        endcase
    end

    // Status outputs are pure decodes of the registered state.
    always_comb begin
        bus.flush = (state == ST_FLUSH);
        bus.fault = (state == ST_FAULT);
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;

`ifdef PC_REDIRECT_COUNT_EN
    logic [15:0] count_q;

    // Saturating count of accepted aligned redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
        end else if (count_inc && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.redirect_count = count_q;
`else
    logic unused_count_inc;
    assign unused_count_inc   = count_inc;
    assign bus.redirect_count = 16'h0000;
`endif
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with RESET_PC = 0x100.
// Follows PC_REDIRECT_COUNT_EN for the expected redirect_count.
module tb_pc_next_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef PC_REDIRECT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [15:0] exp_cnt = 16'h0;

    pc_next_if bus ();

    pc_next_unit #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall         = 1'b0;
        bus.opcode        = 3'b001;
        bus.func          = 6'b000000;
        bus.jr_target     = 'z;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 16'h0000;
        bus.jump_index    = 26'h0;
    endtask

    task automatic drive_jr(input logic [31:0] t);
        bus.opcode    = 3'b000;
        bus.func      = 6'b001000;
        bus.jr_target = t;
    endtask

    // Land on addr in RUN: jr to addr-4, then the flush cycle steps to addr.
    task automatic goto(input logic [31:0] addr);
        drive_jr(addr - 32'd4);
        step();
        idle();
        step();
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp_pc, input logic exp_fl);
        n_checks++;
        if (bus.pc !== exp_pc || bus.flush !== exp_fl) begin
            $display("FAIL %s: pc=%h flush=%b, expected pc=%h flush=%b", name, bus.pc, bus.flush, exp_pc, exp_fl);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_cnt(input string name);
        logic [15:0] e;
        e = CNT_EN ? exp_cnt : 16'h0000;
        n_checks++;
        if (bus.redirect_count !== e) begin
            $display("FAIL %s: redirect_count=%h, expected %h", name, bus.redirect_count, e);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.pc !== RST_PC || bus.pc_plus4 !== 32'h104 || bus.flush !== 1'b0 || bus.fault !== 1'b0)
            $display("FAIL reset: pc=%h pc_plus4=%h flush=%b fault=%b, expected 100/104/0/0", bus.pc, bus.pc_plus4, bus.flush, bus.fault);
        else n_pass++;
        chk_cnt("reset_count");
        rst_n = 1'b1;
        step(); chk_pc("seq1", 32'h104, 1'b0);
        step(); chk_pc("seq2", 32'h108, 1'b0);
        step(); chk_pc("seq3", 32'h10C, 1'b0);
        n_checks++;
        if (bus.fault !== 1'b0) $display("FAIL seq_fault: fault=%b, expected 0", bus.fault);
        else n_pass++;
    endtask

    task automatic test_jr();
        goto(32'h200);
        chk_pc("goto_200", 32'h200, 1'b0);
        drive_jr(32'h400);
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk_pc("jr_target", 32'h400, 1'b1);
        chk_cnt("jr_count");
        idle();
        step();
        chk_pc("jr_after_flush", 32'h404, 1'b0);
    endtask

    task automatic test_priority();
        goto(32'h200);
        bus.opcode        = 3'b010;
        bus.jump_index    = 26'h40;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 16'hFFFF;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk_pc("jump_wins", 32'h100, 1'b1);
        bus.opcode = 3'b001;
        step();
        chk_pc("flush_ignores_branch", 32'h104, 1'b0);
        bus.branch_offset = 16'h0003;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk_pc("branch_fwd", 32'h114, 1'b1);
        idle();
        step();
        chk_pc("branch_fwd_flush", 32'h118, 1'b0);
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 16'hFFFF;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk_pc("branch_self", 32'h118, 1'b1);
        idle();
        step();
        chk_pc("branch_self_flush", 32'h11C, 1'b0);
        chk_cnt("priority_count");
    endtask

    task automatic test_stall();
        goto(32'h200);
        drive_jr(32'h400);
        bus.stall = 1'b1;
        step(); chk_pc("stall1", 32'h200, 1'b0);
        step(); chk_pc("stall2", 32'h200, 1'b0);
        chk_cnt("stall_count");
        bus.stall = 1'b0;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk_pc("stall_release", 32'h400, 1'b1);
        idle();
        bus.stall = 1'b1;
        step(); chk_pc("stall_in_flush", 32'h400, 1'b1);
        bus.stall = 1'b0;
        step(); chk_pc("stall_flush_release", 32'h404, 1'b0);
    endtask

    task automatic test_wrap();
        goto(32'hFFFF_FFFC);
        chk_pc("at_top", 32'hFFFF_FFFC, 1'b0);
        n_checks++;
        if (bus.pc_plus4 !== 32'h0) $display("FAIL top_plus4: pc_plus4=%h, expected 00000000", bus.pc_plus4);
        else n_pass++;
        step();
        chk_pc("wrap", 32'h0, 1'b0);
        n_checks++;
        if (bus.fault !== 1'b0 || bus.pc_plus4 !== 32'h4)
            $display("FAIL wrap_status: fault=%b pc_plus4=%h, expected 0/00000004", bus.fault, bus.pc_plus4);
        else n_pass++;
    endtask

    task automatic test_fault();
        goto(32'h200);
        drive_jr(32'h402);
        step();
        chk_pc("fault_pc", 32'h200, 1'b0);
        n_checks++;
        if (bus.fault !== 1'b1) $display("FAIL fault_set: fault=%b, expected 1", bus.fault);
        else n_pass++;
        chk_cnt("fault_not_counted");
        drive_jr(32'h800);
        bus.branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus.pc !== 32'h200 || bus.fault !== 1'b1 || bus.flush !== 1'b0)
                $display("FAIL fault_hold%0d: pc=%h fault=%b flush=%b, expected 200/1/0", i, bus.pc, bus.fault, bus.flush);
            else n_pass++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 16'h0;
        n_checks++;
        if (bus.pc !== RST_PC || bus.fault !== 1'b0 || bus.flush !== 1'b0)
            $display("FAIL fault_reset: pc=%h fault=%b flush=%b, expected 100/0/0", bus.pc, bus.fault, bus.flush);
        else n_pass++;
        chk_cnt("fault_reset_count");
        idle();
        step();
        rst_n = 1'b1;
        step();
        chk_pc("post_reset_seq", 32'h104, 1'b0);
    endtask

    initial begin
        idle();
        test_reset();
        test_jr();
        test_priority();
        test_stall();
        test_wrap();
        test_fault();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
